// File: rtl/blaster_pulse_scheduler.sv
// Round-robin scheduler that shares one stretched pulse output among N_CH requesters.
// Each pulse is followed by a forced low gap so pulses from different channels never merge.
module blaster_pulse_scheduler #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned BIT_WIDTH = 6,
    parameter int unsigned GAP       = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_CH-1:0]           i_req,
    input  logic [N_CH*BIT_WIDTH-1:0] i_len,
    input  logic                      i_clr_ovr,
    output logic                      o_pulse,
    output logic [N_CH-1:0]           o_grant,
    output logic [N_CH-1:0]           o_pending,
    output logic [N_CH-1:0]           o_overrun,
    output logic                      o_busy
);

    localparam int unsigned GapW = $clog2(GAP + 1);
    localparam int unsigned CntW = (BIT_WIDTH > GapW) ? BIT_WIDTH : GapW;
    localparam int unsigned PtrW = $clog2(N_CH);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [N_CH-1:0]      pending_q, pending_d;
    logic [N_CH-1:0]      overrun_q, overrun_d;
    logic [N_CH-1:0]      grant_q, grant_d;
    logic [BIT_WIDTH-1:0] len_q [N_CH];
    logic [BIT_WIDTH-1:0] len_d [N_CH];

    logic                 found;
    logic [PtrW-1:0]      win;
    logic                 grant_now;
    logic [N_CH-1:0]      win_oh;

    // Search pending from the pointer upward, wrapping explicitly at N_CH-1.
    always_comb begin : arb
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && pending_q[PtrW'(idx)]) begin
                found = 1'b1;
                win   = PtrW'(idx);
            end
        end
    end

    assign grant_now = (state_q == StIdle) && found;
    assign win_oh    = grant_now ? (N_CH'(1) << win) : '0;

    // A strobe on the edge that grants its own channel re-arms it instead of overrunning.
    always_comb begin
        pending_d = pending_q;
        overrun_d = i_clr_ovr ? '0 : overrun_q;
        len_d     = len_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (i_req[k]) begin
                if (!pending_q[k] || win_oh[k]) begin
                    pending_d[k] = 1'b1;
                    len_d[k]     = i_len[k*BIT_WIDTH +: BIT_WIDTH];
                end else begin
                    overrun_d[k] = 1'b1;
                end
            end else if (win_oh[k]) begin
                pending_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            grant_q   <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                len_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            grant_q   <= grant_d;
            len_q     <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (grant_now) begin
                    state_d = StPulse;
                    cnt_d   = CntW'(len_q[win]);
                    grant_d = win_oh;
                    ptr_d   = (win == PtrW'(N_CH - 1)) ? '0 : win + PtrW'(1);
                end
            end
            StPulse: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    grant_d = '0;
                    if (GAP == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        cnt_d   = CntW'(GAP - 1);
                    end
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_pulse   = (state_q == StPulse);
        o_busy    = (state_q != StIdle);
        o_grant   = grant_q;
        o_pending = pending_q;
        o_overrun = overrun_q;
    end

endmodule

// File: tb/tb_blaster_pulse_scheduler.sv
// Scoreboard bench for blaster_pulse_scheduler: expected pulses are queued at stimulus time
// and compared (owner, width, spacing) as each pulse completes on the output.
module tb_blaster_pulse_scheduler;

    localparam int unsigned N_CH = 4;
    localparam int unsigned BW   = 6;
    localparam int unsigned GAP  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clr = 1'b0;
    logic [N_CH-1:0]      req = '0;
    logic [N_CH*BW-1:0]   len = '0;
    logic                 o_pulse;
    logic [N_CH-1:0]      o_grant;
    logic [N_CH-1:0]      o_pending;
    logic [N_CH-1:0]      o_overrun;
    logic                 o_busy;

    blaster_pulse_scheduler #(
        .N_CH      (N_CH),
        .BIT_WIDTH (BW),
        .GAP       (GAP)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_len     (len),
        .i_clr_ovr (clr),
        .o_pulse   (o_pulse),
        .o_grant   (o_grant),
        .o_pending (o_pending),
        .o_overrun (o_overrun),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0] grant;
        int unsigned     width;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    logic            in_pulse  = 1'b0;
    int unsigned     width     = 0;
    int unsigned     low_cnt   = 0;
    bit              gap_armed = 1'b0;
    bit              check_gap = 1'b0;
    bit              chk_pend  = 1'b0;
    logic [N_CH-1:0] exp_pend  = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CH*BW-1:0] lens(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        return {BW'(d), BW'(c), BW'(b), BW'(a)};
    endfunction

    function automatic exp_t mk(input logic [N_CH-1:0] g, input int unsigned w);
        exp_t e;
        e.grant = g;
        e.width = w;
        return e;
    endfunction

    task automatic drive(input logic [N_CH-1:0] m, input logic [N_CH*BW-1:0] l);
        @(negedge clk);
        req = m;
        len = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned max);
        int unsigned n = 0;
        while ((sb.size() != 0 || o_busy !== 1'b0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    // Pulse monitor: measures each high run and the low run preceding it.
    always @(negedge clk) begin
        if (o_pulse === 1'b1) begin
            if (!in_pulse) begin
                if (check_gap && gap_armed) check_eq("gap_low", low_cnt, GAP + 1);
                if (sb.size() != 0) begin
                    check_eq("grant", 32'(o_grant), 32'(sb[0].grant));
                    if (chk_pend) begin
                        exp_pend = exp_pend & ~sb[0].grant;
                        check_eq("pending_dec", 32'(o_pending), 32'(exp_pend));
                    end
                end
                width = 0;
            end
            width++;
            in_pulse = 1'b1;
        end else begin
            if (in_pulse) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check_eq("width", width, mon_e.width);
                end
                check_eq("grant_idle", 32'(o_grant), 32'd0);
                gap_armed = 1'b1;
                low_cnt   = 1;
            end else begin
                low_cnt++;
            end
            in_pulse = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_pulse", 32'(o_pulse), 32'd0);
        check_eq("rst_grant", 32'(o_grant), 32'd0);
        check_eq("rst_pend", 32'(o_pending), 32'd0);
        check_eq("rst_ovr", 32'(o_overrun), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;

        // Single request: latency, width, busy span
        sb.push_back(mk(4'b0001, 4));
        drive(4'b0001, lens(3, 0, 0, 0));
        drive(4'b0000, '0);
        check_eq("lat_pulse0", 32'(o_pulse), 32'd0);
        check_eq("lat_pend", 32'(o_pending), 32'h1);
        @(negedge clk);
        check_eq("lat_pulse1", 32'(o_pulse), 32'd1);
        check_eq("lat_grant", 32'(o_grant), 32'h1);
        repeat (4 + GAP - 1) @(negedge clk);
        check_eq("busy_tail", 32'(o_busy), 32'd1);
        @(negedge clk);
        check_eq("busy_done", 32'(o_busy), 32'd0);
        wait_drain(50);

        // Simultaneous requests: in-order service, exact gaps, pending shrinks
        do_reset();
        gap_armed = 1'b0;
        check_gap = 1'b1;
        chk_pend  = 1'b1;
        exp_pend  = 4'b1111;
        sb.push_back(mk(4'b0001, 1));
        sb.push_back(mk(4'b0010, 2));
        sb.push_back(mk(4'b0100, 3));
        sb.push_back(mk(4'b1000, 4));
        drive(4'b1111, lens(0, 1, 2, 3));
        drive(4'b0000, '0);
        check_eq("pend_all", 32'(o_pending), 32'hf);
        wait_drain(100);
        check_gap = 1'b0;
        chk_pend  = 1'b0;

        // Fairness: ch2 served before ch0's re-request
        do_reset();
        sb.push_back(mk(4'b0001, 4));
        sb.push_back(mk(4'b0100, 5));
        sb.push_back(mk(4'b0001, 2));
        drive(4'b0001, lens(3, 0, 0, 0));
        drive(4'b0000, '0);
        drive(4'b0101, lens(1, 0, 4, 0));
        drive(4'b0000, '0);
        wait_drain(100);

        // Overrun: second strobe while pending keeps original length, clear works
        do_reset();
        sb.push_back(mk(4'b0001, 10));
        sb.push_back(mk(4'b0010, 3));
        drive(4'b0001, lens(9, 0, 0, 0));
        drive(4'b0010, lens(0, 2, 0, 0));
        drive(4'b0010, lens(0, 7, 0, 0));
        check_eq("ovr_pre", 32'(o_overrun), 32'd0);
        drive(4'b0000, '0);
        check_eq("ovr_set", 32'(o_overrun), 32'h2);
        check_eq("ovr_pend", 32'(o_pending), 32'h2);
        @(negedge clk);
        clr = 1'b1;
        check_eq("ovr_hold", 32'(o_overrun), 32'h2);
        @(negedge clk);
        clr = 1'b0;
        check_eq("ovr_clr", 32'(o_overrun), 32'd0);
        wait_drain(100);

        // Request on the grant edge: old length now, new length next, no overrun
        do_reset();
        sb.push_back(mk(4'b0001, 2));
        sb.push_back(mk(4'b0001, 6));
        drive(4'b0001, lens(1, 0, 0, 0));
        drive(4'b0001, lens(5, 0, 0, 0));
        drive(4'b0000, '0);
        check_eq("ge_pend", 32'(o_pending), 32'h1);
        check_eq("ge_ovr", 32'(o_overrun), 32'd0);
        wait_drain(100);
        check_eq("ge_ovr_end", 32'(o_overrun), 32'd0);

        // Reset mid-pulse: pulse truncated to two cycles, pending ch3 discarded
        do_reset();
        sb.push_back(mk(4'b0001, 2));
        drive(4'b0001, lens(9, 0, 0, 0));
        drive(4'b1000, lens(0, 0, 0, 7));
        drive(4'b0000, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rm_pulse", 32'(o_pulse), 32'd0);
        check_eq("rm_pend", 32'(o_pending), 32'd0);
        check_eq("rm_grant", 32'(o_grant), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("rm_quiet", 32'(sb.size()), 32'd0);
        check_eq("rm_busy", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blaster_pulse_scheduler.md
Name: blaster_pulse_scheduler

Overview:
- Shares one pulse-stretching output among N requesters, such as activity LEDs and strobe indicators on the blaster.
- Each requester posts a one-cycle strobe together with a pulse length. The block latches the request and arbitrates round-robin.
- The winner's pulse is emitted on a single stretched output, followed by a fixed low gap, so pulses from different channels never merge.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- BIT_WIDTH, 6, width of each pulse-length field.
- GAP, 2, number of forced low cycles after every pulse (0 allowed).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_req  in  N_CH  per-channel request strobe, sampled every rising edge
- i_len  in  N_CH*BIT_WIDTH  per-channel length; channel k occupies bits [k*BIT_WIDTH +: BIT_WIDTH]
- i_clr_ovr  in  1  clears all overrun flags
- o_pulse  out  1  stretched output pulse
- o_grant  out  N_CH  one-hot owner of the current pulse; zero when no pulse is active
- o_pending  out  N_CH  latched, not-yet-served requests
- o_overrun  out  N_CH  sticky flag: request was lost because the channel was already pending
- o_busy  out  1  high while in PULSE or GAP

Behaviour:
- Reset (i_rst=1 at an edge) forces, from the next cycle:
  - state=IDLE; o_pulse=0, o_grant=0, o_pending=0, o_overrun=0, o_busy=0
  - round-robin pointer=0; counter=0
- Reset mid-pulse aborts the pulse immediately; pending requests are discarded.
- Request capture, per channel k, each edge:
  - i_req[k]=1 and pending[k]=0 → pending[k]=1 and len_q[k]=i_len slice. The length is frozen at capture.
  - i_req[k]=1 and pending[k]=1 and channel k is not being granted this edge → request dropped, overrun[k]=1, len_q[k] unchanged.
  - i_req[k]=1 on the same edge that grants channel k → the new request is captured (pending[k] stays 1, len_q[k] updated). The grant uses the old len_q[k]. No overrun.
- Overrun:
  - i_clr_ovr clears overrun on the next edge.
  - A simultaneous new overrun event wins (flag stays 1).
- Arbitration:
  - Round-robin over pending, starting at pointer p and searching p, p+1, ... wrapping at N_CH-1→0.
  - After granting channel k, p=(k+1) mod N_CH.
- FSM states IDLE, PULSE, GAP:
  - IDLE:
    - pending≠0 at an edge → PULSE; o_pulse=1, o_grant=onehot(k), counter=len_q[k], pending[k] cleared.
    - otherwise stay in IDLE.
  - PULSE, each edge:
    - counter≠0 → counter-1.
    - counter=0 → o_pulse=0, o_grant=0; go to GAP with counter=GAP-1, or to IDLE if GAP=0.
  - GAP, each edge:
    - counter≠0 → counter-1.
    - counter=0 → IDLE.
- Timing:
  - Pulse width = len_q+1 cycles; len=0 gives 1 cycle, len=2^BIT_WIDTH-1 gives 2^BIT_WIDTH cycles.
  - Latency: i_req sampled at edge E0 → pending at E0 → o_pulse high after E1. Two edges from strobe to output when idle.
  - Back-to-back pulses are separated by exactly GAP+1 low cycles (GAP cycles in GAP plus one IDLE cycle).
- o_busy = (state≠IDLE). All outputs are registered; no combinational path from inputs to outputs.
- Widths:
  - counter is max(BIT_WIDTH, clog2(GAP+1)) bits.
  - Pointer is clog2(N_CH) bits; wrap is explicit, not a power-of-2 overflow.

Test Plan:
- Reset then single request: i_req=0001, len0=3 → o_pulse high for exactly 4 cycles starting 2 edges after the strobe; o_grant=0001 throughout; o_busy low again after 4+GAP+1 cycles.
- Simultaneous requests: i_req=1111, lens 0/1/2/3, GAP=2 → grants in order ch0, ch1, ch2, ch3 with widths 1/2/3/4. Exactly 3 low cycles between pulses; o_pending decrements one bit per grant.
- Round-robin fairness: ch0 re-requests after every grant while ch2 requests once → ch2 is served immediately after the current ch0 pulse, not starved.
- Overrun: ch1 pending (not granted), second i_req[1] → o_overrun=0010 and the original length is used. Asserting i_clr_ovr → o_overrun=0 next cycle.
- Request on the grant edge: i_req[0] on the same edge ch0 is granted with new len=5 → current pulse uses the old length; a second ch0 pulse of 6 cycles follows; no overrun.
- Reset mid-pulse: i_rst asserted in cycle 2 of a 10-cycle pulse while ch3 is pending → next cycle o_pulse=0, o_pending=0, o_grant=0. No pulse follows until a new request arrives.
